// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first sequential adder built around one full-adder cell.
//   Operands are captured in parallel, then one bit per cycle is fed through
//   the cell with a registered carry. After WIDTH shift cycles the parallel
//   result is published with a one-cycle done pulse, carry-out and signed
//   overflow.
//
// Parameters
//   WIDTH  operand/result width, legal range 2..32
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE or DONE
//   a, b   operands, captured on the accepting edge
//   sub    subtract select, captured with the operands
//   busy   high while bits are being shifted through the cell
//   done   one-cycle completion pulse
//   sum    result, updated only on the edge entering DONE
//   cout   final carry out (for subtract, 1 = no borrow)
//   ovf    signed two's-complement overflow
//
// Configuration
//   BIT_SERIAL_ADDER_SUB_EN  when defined, sub selects A-B (B inverted,
//                            carry-in 1); otherwise sub is ignored and every
//                            operation is A+B.

module bit_serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s_bit, c_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  bit_serial_fa u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (c),
    .s  (s_bit),
    .co (c_next)
  );

`ifdef BIT_SERIAL_ADDER_SUB_EN
  // A-B is A + ~B + 1: invert on load, seed the carry with 1.
  assign b_load = sub ? ~b : b;
  assign c_load = sub;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign b_load     = b;
  assign c_load     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            c     <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          c      <= c_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            // Last bit: publish directly so the result is valid with done.
            sum   <= {s_bit, sum_sr[WIDTH-1:1]};
            cout  <= c_next;
            ovf   <= c ^ c_next;  // carry into MSB vs carry out of MSB
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
